// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg -- constants shared by the USB datapath blocks (data_buffer, usb_tx).
//
// USB_FIFO_DEPTH : byte capacity of the shared packet FIFO (power of two)
// USB_OCC_W      : width of an occupancy count, must hold 0..USB_FIFO_DEPTH
// USB_PTR_W      : width of a FIFO read/write pointer, wraps at depth-1 -> 0
// ---------------------------------------------------------------------------
package usb_pkg;

  localparam int unsigned USB_FIFO_DEPTH = 64;
  localparam int unsigned USB_OCC_W      = 7;
  localparam int unsigned USB_PTR_W      = 6;

endpackage

// File: rtl/data_buffer_fifo_ram.sv
// ---------------------------------------------------------------------------
// fifo_ram -- storage array of the shared packet FIFO with one write port and
// one combinational (show-ahead) read port.
//
// Ports:
//   clk   : rising-edge clock for the write port
//   n_rst : asynchronous active-low reset, zeroes every byte of the array
//   we    : write enable, stores wdata at waddr on the rising edge
//   waddr : write address
//   wdata : byte to write
//   raddr : read address
//   rdata : array[raddr], combinational
// ---------------------------------------------------------------------------
module fifo_ram
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = USB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 we,
  input  logic [USB_PTR_W-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [USB_PTR_W-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [DEPTH];

  // The whole array is cleared on reset so the head reads 8'h00 afterwards.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= 8'h00;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_buffer.sv
// ---------------------------------------------------------------------------
// data_buffer -- shared byte FIFO between the host (AHB) side and the USB
// side. Either side may push or pop; the head byte is presented show-ahead on
// both tx_packet_data and rx_data.
//
// Ports:
//   clk                  : system clock, rising edge
//   n_rst                : asynchronous active-low reset
//   store_tx_data        : push tx_data (host side)
//   tx_data              : byte for store_tx_data
//   store_rx_packet_data : push rx_packet_data (USB RX side), wins over tx
//   rx_packet_data       : byte for store_rx_packet_data
//   get_tx_packet_data   : pop request (usb_tx)
//   get_rx_data          : pop request (host)
//   clear, flush         : synchronous empty, override push/pop that cycle
//   tx_packet_data       : head byte
//   rx_data              : head byte (same value)
//   buffer_occupancy     : bytes stored, 0..DEPTH
//   buffer_error         : sticky misuse flag, only when DATA_BUFFER_ERR_EN
//
// Optional feature: define DATA_BUFFER_ERR_EN to add buffer_error.
//
// Push/pop semantics: a push or pop request is a single-cycle strobe sampled
// on the rising edge; there is no back-pressure. A pop while empty and a push
// while full (without a simultaneous pop) are silently dropped. When both
// push strobes are high, rx_packet_data is written and tx_data is dropped.
// When both pop strobes are high, exactly one byte is popped.
// ---------------------------------------------------------------------------
module data_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = USB_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 store_tx_data,
  input  logic [7:0]           tx_data,
  input  logic                 store_rx_packet_data,
  input  logic [7:0]           rx_packet_data,
  input  logic                 get_tx_packet_data,
  input  logic                 get_rx_data,
  input  logic                 clear,
  input  logic                 flush,
  output logic [7:0]           tx_packet_data,
  output logic [7:0]           rx_data,
`ifdef DATA_BUFFER_ERR_EN
  output logic                 buffer_error,
`endif
  output logic [USB_OCC_W-1:0] buffer_occupancy
);

  logic [USB_PTR_W-1:0] rd_ptr;
  logic [USB_PTR_W-1:0] wr_ptr;
  logic [USB_OCC_W-1:0] occ;
  logic [7:0]           head;

  logic       push_req;
  logic       pop_req;
  logic [7:0] push_byte;
  logic       empty;
  logic       full;
  logic       do_pop;
  logic       do_push;
  logic       empty_req;

  assign push_req  = store_rx_packet_data | store_tx_data;
  assign pop_req   = get_tx_packet_data | get_rx_data;
  assign push_byte = store_rx_packet_data ? rx_packet_data : tx_data;
  assign empty_req = clear | flush;

  assign empty = (occ == '0);
  assign full  = (occ == USB_OCC_W'(DEPTH));

  // A push into a full buffer is accepted only when a pop frees a slot on the
  // same edge; push+pop on an empty buffer degenerates to push only.
  assign do_pop  = pop_req & ~empty;
  assign do_push = push_req & (~full | do_pop);

  fifo_ram #(
    .DEPTH (DEPTH)
  ) u_fifo_ram (
    .clk   (clk),
    .n_rst (n_rst),
    .we    (do_push & ~empty_req),
    .waddr (wr_ptr),
    .wdata (push_byte),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (empty_req) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        occ <= occ + 1'b1;
      end else if (do_pop && !do_push) begin
        occ <= occ - 1'b1;
      end
    end
  end

`ifdef DATA_BUFFER_ERR_EN
  logic err_event;

  // Dropped push (full with no pop, or tx_data lost to rx) or ignored pop.
  assign err_event = (push_req & full & ~do_pop)
                   | (store_rx_packet_data & store_tx_data)
                   | (pop_req & empty);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      buffer_error <= 1'b0;
    end else if (empty_req) begin
      buffer_error <= 1'b0;
    end else if (err_event) begin
      buffer_error <= 1'b1;
    end
  end
`endif

  assign tx_packet_data   = head;
  assign rx_data          = head;
  assign buffer_occupancy = occ;

endmodule

// File: tb/tb_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_data_buffer -- self-checking bench for data_buffer. A queue-based model
// of the FIFO is compared with the DUT on every falling edge; directed
// sequences additionally check hand-computed literal values.
// ---------------------------------------------------------------------------
module tb_data_buffer;
  import usb_pkg::*;

  // ---------------- clock / reset ----------------
  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  always #5 tb_clk = ~tb_clk;

  // ---------------- DUT signals ----------------
  logic                 store_tx_data        = 1'b0;
  logic [7:0]           tx_data              = 8'h00;
  logic                 store_rx_packet_data = 1'b0;
  logic [7:0]           rx_packet_data       = 8'h00;
  logic                 get_tx_packet_data   = 1'b0;
  logic                 get_rx_data          = 1'b0;
  logic                 clear                = 1'b0;
  logic                 flush                = 1'b0;
  logic [7:0]           tx_packet_data;
  logic [7:0]           rx_data;
  logic [USB_OCC_W-1:0] buffer_occupancy;
  logic                 buffer_error;

  data_buffer dut (
    .clk                  (tb_clk),
    .n_rst                (n_rst),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .get_rx_data          (get_rx_data),
    .clear                (clear),
    .flush                (flush),
    .tx_packet_data       (tx_packet_data),
    .rx_data              (rx_data),
`ifdef DATA_BUFFER_ERR_EN
    .buffer_error         (buffer_error),
`endif
    .buffer_occupancy     (buffer_occupancy)
  );

`ifndef DATA_BUFFER_ERR_EN
  assign buffer_error = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: the FIFO is just an ordered queue of bytes, capacity 64.
  logic [7:0] exp_q[$];
  logic       exp_err = 1'b0;

  always @(posedge tb_clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      exp_err <= 1'b0;
    end else if (clear || flush) begin
      exp_q.delete();
      exp_err <= 1'b0;
    end else begin
      automatic bit       want_push = store_tx_data || store_rx_packet_data;
      automatic bit       want_pop  = get_tx_packet_data || get_rx_data;
      automatic logic [7:0] b       = store_rx_packet_data ? rx_packet_data : tx_data;
      automatic int       n         = exp_q.size();
      automatic bit       popped    = want_pop && (n > 0);
      if (want_pop && n == 0) exp_err <= 1'b1;
      if (want_push && n == 64 && !popped) exp_err <= 1'b1;
      if (store_tx_data && store_rx_packet_data) exp_err <= 1'b1;
      if (popped) void'(exp_q.pop_front());
      if (want_push && (n < 64 || popped)) exp_q.push_back(b);
    end
  end

  // Compare process: outputs only change on a rising edge or on reset.
  always @(negedge tb_clk) begin
    check("occupancy", int'(buffer_occupancy), exp_q.size());
    if (exp_q.size() > 0) begin
      check("tx_packet_data", int'(tx_packet_data), int'(exp_q[0]));
      check("rx_data", int'(rx_data), int'(exp_q[0]));
    end
`ifdef DATA_BUFFER_ERR_EN
    check("buffer_error", int'(buffer_error), int'(exp_err));
`endif
  end

  // ---------------- driver ----------------
  // Applies one cycle of strobes, waits past the rising edge, then idles.
  task automatic cycle(input bit stx, input logic [7:0] txd,
                       input bit srx, input logic [7:0] rxd,
                       input bit gtx, input bit grx,
                       input bit clr, input bit fl);
    store_tx_data        = stx;
    tx_data              = txd;
    store_rx_packet_data = srx;
    rx_packet_data       = rxd;
    get_tx_packet_data   = gtx;
    get_rx_data          = grx;
    clear                = clr;
    flush                = fl;
    @(posedge tb_clk);
    #1;
    store_tx_data        = 1'b0;
    store_rx_packet_data = 1'b0;
    get_tx_packet_data   = 1'b0;
    get_rx_data          = 1'b0;
    clear                = 1'b0;
    flush                = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d);
    cycle(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop_tx();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #12;
    check("reset_occ", int'(buffer_occupancy), 0);
    check("reset_head", int'(tx_packet_data), 8'h00);
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;
    idle();
    check("post_reset_occ", int'(buffer_occupancy), 0);
    check("post_reset_head", int'(rx_data), 8'h00);

    // Basic ordering.
    push_tx(8'hB5);
    push_tx(8'hFF);
    push_tx(8'h01);
    check("three_push_occ", int'(buffer_occupancy), 3);
    check("three_push_head", int'(tx_packet_data), 8'hB5);
    pop_tx();
    check("pop1_head", int'(tx_packet_data), 8'hFF);
    pop_tx();
    check("pop2_head", int'(tx_packet_data), 8'h01);
    pop_tx();
    check("pop3_occ", int'(buffer_occupancy), 0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 64; i++) push_tx(8'(i));
    check("full_occ", int'(buffer_occupancy), 64);
    push_tx(8'hAA);
    check("overflow_occ", int'(buffer_occupancy), 64);
    check("overflow_head", int'(tx_packet_data), 8'h00);
`ifdef DATA_BUFFER_ERR_EN
    check("overflow_err", int'(buffer_error), 1);
`endif

    // Push+pop while full.
    cycle(1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("full_pushpop_occ", int'(buffer_occupancy), 64);
    check("full_pushpop_head", int'(tx_packet_data), 8'h01);
    for (int i = 0; i < 63; i++) pop_tx();
    check("last_byte", int'(tx_packet_data), 8'h40);
    check("last_occ", int'(buffer_occupancy), 1);
    pop_tx();
    check("drained_occ", int'(buffer_occupancy), 0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef DATA_BUFFER_ERR_EN
    check("flush_clears_err", int'(buffer_error), 0);
`endif

    // Empty push+pop is push only; dual push keeps rx byte.
    cycle(1'b1, 8'h19, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("empty_pushpop_occ", int'(buffer_occupancy), 1);
    check("empty_pushpop_head", int'(rx_data), 8'h19);
    cycle(1'b1, 8'h05, 1'b1, 8'h91, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dual_push_occ", int'(buffer_occupancy), 2);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("dual_pop_occ", int'(buffer_occupancy), 1);
    check("dual_push_head", int'(tx_packet_data), 8'h91);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("clear_occ", int'(buffer_occupancy), 0);

    // Flush overrides a simultaneous push.
    for (int i = 0; i < 10; i++) push_tx(8'(i * 7 + 3));
    check("ten_occ", int'(buffer_occupancy), 10);
    cycle(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_occ", int'(buffer_occupancy), 0);
    push_tx(8'h33);
    check("after_flush_head", int'(tx_packet_data), 8'h33);
    check("after_flush_occ", int'(buffer_occupancy), 1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 4; i++) push_tx(8'hC0 + 8'(i));
    check("five_occ", int'(buffer_occupancy), 5);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset_occ", int'(buffer_occupancy), 0);
    check("async_reset_head", int'(tx_packet_data), 8'h00);
    @(posedge tb_clk);
    #1;
    n_rst = 1'b1;
    idle();

    // Mixed traffic checked by the model.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 2) != 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 80) == 0));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_buffer.md
DATA_BUFFER -- requirements
Module: data_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning byte capacity of the shared packet FIFO (power of two).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port n_rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port store_tx_data  input  1  push tx_data (host/AHB side).
REQ-005 SHALL have port tx_data  input  8  byte to push on store_tx_data.
REQ-006 SHALL have port store_rx_packet_data  input  1  push rx_packet_data (USB RX side).
REQ-007 SHALL have port rx_packet_data  input  8  byte to push on store_rx_packet_data.
REQ-008 SHALL have port get_tx_packet_data  input  1  pop request from usb_tx.
REQ-009 SHALL have port get_rx_data  input  1  pop request from host side.
REQ-010 SHALL have port clear  input  1  synchronous empty request (host).
REQ-011 SHALL have port flush  input  1  synchronous empty request (protocol side).
REQ-012 SHALL have port tx_packet_data  output  8  head byte, show-ahead.
REQ-013 SHALL have port rx_data  output  8  head byte, show-ahead (same value as tx_packet_data).
REQ-014 SHALL have port buffer_occupancy  output  7  bytes stored, 0..64.

Function
REQ-015 SHALL store bytes in a circular array with 6-bit read and write pointers wrapping 63 -> 0.
REQ-016 SHALL drive tx_packet_data and rx_data combinationally from array[read pointer]; value while empty is don't-care but SHALL be 8'h00 after reset.
REQ-017 SHALL treat push = store_rx_packet_data | store_tx_data; if both are high, rx_packet_data is written and tx_data is dropped.
REQ-018 SHALL treat pop = get_tx_packet_data | get_rx_data; both high performs a single pop.
REQ-019 SHALL write the pushed byte at the write pointer and increment it on the same edge; written byte is visible on the head no earlier than the next cycle.
REQ-020 SHALL increment the read pointer on a pop edge, exposing the next byte the following cycle.
REQ-021 SHALL ignore pop while occupancy = 0 (pointers, occupancy unchanged), including push+pop when empty (push only).
REQ-022 SHALL ignore push while occupancy = 64, except push+pop when full, where both are performed and occupancy stays 64.
REQ-023 SHALL update occupancy: +1 push only, -1 pop only, unchanged push+pop, never outside 0..64.
REQ-024 SHALL, on clear or flush high, reset both pointers and occupancy to 0 at the next edge, overriding any push/pop that cycle; array contents are not erased.

Reset
REQ-025 SHALL asynchronously set pointers, occupancy and all array bytes to 0 when n_rst is low, regardless of clk.
REQ-026 SHALL resume normal operation on the first rising edge after n_rst deasserts; reset mid-packet discards all stored data.

Configuration
REQ-027 SHALL, with DATA_BUFFER_ERR_EN defined, add output buffer_error (1 bit), a sticky flag set on the edge after a dropped push (full, or tx_data dropped per REQ-017) or an ignored pop (empty), cleared by clear, flush or reset.
REQ-028 SHALL, without DATA_BUFFER_ERR_EN, have no buffer_error port and no associated logic; all other behaviour identical.

Structure
REQ-029 SHALL take DEPTH default, occupancy width (7) and pointer width (6) from the shared package usb_pkg, which usb_tx also imports.
REQ-030 SHALL place the storage array and its write port in one sub-module, fifo_ram; pointer and occupancy control remain in data_buffer.

Verification
REQ-031 Reset, then push 8'hB5, 8'hFF, 8'h01 via store_tx_data -> occupancy 3; three get_tx_packet_data pops read B5, FF, 01 in order; occupancy 0.
REQ-032 Push 64 bytes 0..63, then a 65th (8'hAA) -> occupancy stays 64, 8'hAA not stored, buffer_error = 1 when enabled; head = 8'h00.
REQ-033 At occupancy 64, push 8'h40 with get_tx_packet_data in same cycle -> occupancy 64, head becomes 8'h01, 8'h40 read as the 64th byte.
REQ-034 Empty buffer, push 8'h19 with get_rx_data same cycle -> occupancy 1, head 8'h19 next cycle; store_tx_data and store_rx_packet_data together with 8'h05/8'h91 -> only 8'h91 stored.
REQ-035 Occupancy 10, assert flush with a simultaneous push -> occupancy 0 next cycle; subsequent push 8'h33 appears at head.
REQ-036 Occupancy 5, pull n_rst low between edges -> occupancy and head read 0 immediately, before the next clk edge.
